// File: rtl/ct_f_spsram_param.sv
// Behavioural single-port SRAM with active-low enables.
// Ports: A address, CEN chip enable (low), CLK clock,
//        D write data, GWEN global write enable (low),
//        WEN per-bit write enable (low), Q registered read data.
module ct_f_spsram_param #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  CLK,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] Q
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array and Q are deliberately not reset; Q only
  // changes on a read access.
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      end else begin
        Q <= mem[A];
      end
    end
  end

endmodule

// File: rtl/ct_spsram_pctrl.sv
// Single-port SRAM controller: zero-fill after reset, then
// one read or masked write per cycle with 1/2-cycle read latency.
// Ports: forever_cpuclk clock, cpurst_b async reset (low),
//        req_vld/req_rdy/req_write/req_addr/req_wdata/req_wmask request,
//        rdata_vld/rdata read return, init_done fill complete.
module ct_spsram_pctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter bit OUT_REG    = 1'b0,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rdata_vld,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam state_e RST_ST = INIT_EN ? ST_INIT : ST_RUN;
  localparam logic   RST_DONE = !INIT_EN;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic rd1_q, rd1_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  logic                  sram_cen;
  logic                  sram_gwen;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [DATA_WIDTH-1:0] sram_q;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
      done_q  <= RST_DONE;
      rd1_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rd1_q   <= rd1_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    rd1_d     = 1'b0;
    req_rdy   = 1'b0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = req_addr;
    sram_d    = req_wdata;
    unique case (state_q)
      ST_INIT: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = cnt_q;
        sram_d    = '0;
        cnt_d     = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        req_rdy = 1'b1;
        if (req_vld) begin
          if (req_write) begin
            // An all-zero mask is accepted but never
            // touches the macro.
            if (|req_wmask) begin
              sram_cen  = 1'b0;
              sram_gwen = 1'b0;
              sram_wen  = ~req_wmask;
            end
          end else begin
            sram_cen = 1'b0;
            rd1_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = RST_ST;
      end
    endcase
  end

  // Q is valid the cycle after a read; capture it so rdata
  // holds between pulses and is zero before the first read.
  assign hold_d = rd1_q ? sram_q : hold_q;

  if (OUT_REG) begin : g_oreg
    logic rd2_q;
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
        rd2_q <= 1'b0;
      end else begin
        rd2_q <= rd1_q;
      end
    end
    assign rdata_vld = rd2_q;
    assign rdata     = hold_q;
  end else begin : g_noreg
    assign rdata_vld = rd1_q;
    assign rdata     = rd1_q ? sram_q : hold_q;
  end

  assign init_done = done_q;

  ct_f_spsram_param #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sram (
    .A   (sram_a),
    .CEN (sram_cen),
    .CLK (forever_cpuclk),
    .D   (sram_d),
    .GWEN(sram_gwen),
    .WEN (sram_wen),
    .Q   (sram_q)
  );

endmodule

// File: tb/tb_ct_spsram_pctrl.sv
// Bench for ct_spsram_pctrl: three configurations share one
// stimulus stream and are checked against a memory/queue model.
module tb_ct_spsram_pctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_vld = 1'b0;
  logic req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] req_wmask = '0;

  logic rdy [NI];
  logic vld [NI];
  logic done [NI];
  logic [DW-1:0] rd [NI];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ct_spsram_pctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .OUT_REG(1'b0), .INIT_EN(1'b1)
  ) d0 (
    .forever_cpuclk(clk), .cpurst_b(rst_n),
    .req_vld(req_vld), .req_rdy(rdy[0]),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rdata_vld(vld[0]), .rdata(rd[0]),
    .init_done(done[0])
  );

  ct_spsram_pctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .OUT_REG(1'b1), .INIT_EN(1'b1)
  ) d1 (
    .forever_cpuclk(clk), .cpurst_b(rst_n),
    .req_vld(req_vld), .req_rdy(rdy[1]),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rdata_vld(vld[1]), .rdata(rd[1]),
    .init_done(done[1])
  );

  ct_spsram_pctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .OUT_REG(1'b0), .INIT_EN(1'b0)
  ) d2 (
    .forever_cpuclk(clk), .cpurst_b(rst_n),
    .req_vld(req_vld), .req_rdy(rdy[2]),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rdata_vld(vld[2]), .rdata(rd[2]),
    .init_done(done[2])
  );

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int inst;
    int due;
    logic [DW-1:0] data;
    bit known;
  } ent_t;

  ent_t q[$];
  logic [DW-1:0] mem [NI][DEPTH];
  bit kn [NI][DEPTH];
  int ini [NI];
  int cyc = 0;
  logic [DW-1:0] last [NI];
  bit lastk [NI];

  function automatic int oreg(int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic bit ien(int i);
    return (i != 2);
  endfunction

  function automatic bit mrdy(int i);
    return !ien(i) || ini[i] >= DEPTH;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        if (!mrdy(i)) begin
          mem[i][ini[i]] = '0;
          kn[i][ini[i]] = 1'b1;
          ini[i]++;
        end else if (req_vld) begin
          if (req_write) begin
            mem[i][req_addr] = (mem[i][req_addr] & ~req_wmask)
                             | (req_wdata & req_wmask);
            if (req_wmask == '1) kn[i][req_addr] = 1'b1;
          end else begin
            q.push_back('{inst: i, due: cyc + oreg(i),
                          data: mem[i][req_addr],
                          known: kn[i][req_addr]});
          end
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit ve;
    bit ke;
    logic [DW-1:0] de;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        ini[i] = 0;
        last[i] = '0;
        lastk[i] = 1'b1;
      end
      ve = 1'b0;
      ke = 1'b0;
      de = '0;
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (q[k].inst == i) begin
          if (!rst_n || q[k].due < cyc) begin
            q.delete(k);
          end else if (q[k].due == cyc) begin
            ve = 1'b1;
            de = q[k].data;
            ke = q[k].known;
            q.delete(k);
          end
        end
      end
      chk($sformatf("rdy%0d", i), rdy[i], mrdy(i));
      chk($sformatf("done%0d", i), done[i], mrdy(i));
      chk($sformatf("vld%0d", i), vld[i], ve);
      if (ve) begin
        last[i] = de;
        lastk[i] = ke;
      end
      if (lastk[i]) chk($sformatf("rdata%0d", i), rd[i], last[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(bit v, bit w, int a,
                     logic [DW-1:0] d, logic [DW-1:0] m);
    req_vld = v;
    req_write = w;
    req_addr = AW'(a);
    req_wdata = d;
    req_wmask = m;
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    @(negedge clk);
    chk("d2_rdy_first", rdy[2], 1);
    chk("d2_done_first", done[2], 1);
    while (!rdy[0] && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("init_len", n, 16);
    chk("init_done_d0", done[0], 1);
    chk("init_done_d1", done[1], 1);
  endtask

  initial begin
    drv(0, 0, 0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_init();

    for (int a = 0; a < DEPTH; a++) begin
      drv(1, 0, a, '0, '0);
      cyc1();
    end
    drv(0, 0, 0, '0, '0);
    repeat (3) cyc1();

    drv(1, 1, 3, 32'hDEADBEEF, '1);
    cyc1();
    drv(1, 1, 3, 32'h12345678, 32'h0000FFFF);
    cyc1();
    drv(1, 0, 3, '0, '0);
    #1 chk("cen_read", d0.sram_cen, 0);
    cyc1();
    drv(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("rd3_vld_d0", vld[0], 1);
    chk("rd3_data_d0", rd[0], 32'hDEAD5678);
    chk("rd3_early_d1", vld[1], 0);
    @(negedge clk);
    chk("rd3_vld_d1", vld[1], 1);
    chk("rd3_data_d1", rd[1], 32'hDEAD5678);
    chk("rd3_hold_d0", rd[0], 32'hDEAD5678);
    cyc1();

    drv(1, 1, 0, 32'h11, '1);
    cyc1();
    drv(1, 1, 1, 32'h22, '1);
    cyc1();
    drv(1, 1, 2, 32'h33, '1);
    cyc1();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drv(1, 0, i, '0, '0);
      else if (i == 3) drv(1, 1, 0, 32'hFFFFFFFF, '1);
      else drv(0, 0, 0, '0, '0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b_vld%0d", i), vld[1], (i >= 1 && i <= 3));
      if (i >= 1) chk($sformatf("b2b_data%0d", i), rd[1],
                      32'h11 * ((i > 3) ? 3 : i));
    end
    drv(1, 0, 0, '0, '0);
    cyc1();
    drv(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("wr_after_rd", rd[0], 32'hFFFFFFFF);

    drv(1, 1, 5, 32'hA5A5A5A5, '1);
    cyc1();
    drv(1, 0, 5, '0, '0);
    cyc1();
    drv(0, 0, 0, '0, '0);
    #1 chk("cen_idle", d0.sram_cen, 1);
    @(negedge clk);
    chk("wr_rd5", rd[0], 32'hA5A5A5A5);
    drv(1, 1, 5, 32'hFFFFFFFF, '0);
    #1 chk("cen_mask0_d0", d0.sram_cen, 1);
    chk("cen_mask0_d1", d1.sram_cen, 1);
    cyc1();
    drv(1, 0, 5, '0, '0);
    cyc1();
    drv(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("mask0_vld", vld[0], 1);
    chk("mask0_rd5", rd[0], 32'hA5A5A5A5);

    drv(1, 0, 5, '0, '0);
    cyc1();
    rst_n = 1'b0;
    drv(0, 0, 0, '0, '0);
    #1 chk("rst_drop_d0", vld[0], 0);
    repeat (2) cyc1();
    rst_n = 1'b1;
    repeat (7) cyc1();
    rst_n = 1'b0;
    cyc1();
    rst_n = 1'b1;
    wait_init();

    drv(1, 0, 5, '0, '0);
    cyc1();
    drv(1, 0, 3, '0, '0);
    cyc1();
    drv(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("refill_rd3_d0", rd[0], 32'h0);
    chk("keep_rd3_d2", rd[2], 32'hDEAD5678);
    repeat (4) cyc1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ct_spsram_pctrl.md
CT_SPSRAM_PCTRL -- requirements
Module: ct_spsram_pctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SRAM address width; depth = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 32, SRAM data width.
REQ-003 Parameter OUT_REG, default 0, 0 = 1-cycle read latency, 1 = extra output register (2-cycle latency).
REQ-004 Parameter INIT_EN, default 1, 1 = zero-fill whole array after reset, 0 = ready immediately after reset.
REQ-005 forever_cpuclk  input  1  sole clock; all flops rising-edge.
REQ-006 cpurst_b  input  1  reset, asynchronous, active-low.
REQ-007 req_vld  input  1  access request.
REQ-008 req_rdy  output  1  request accepted when req_vld & req_rdy.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_WIDTH  word address.
REQ-011 req_wdata  input  DATA_WIDTH  write data.
REQ-012 req_wmask  input  DATA_WIDTH  per-bit write enable, active-high.
REQ-013 rdata_vld  output  1  one-cycle pulse, rdata valid.
REQ-014 rdata  output  DATA_WIDTH  read data, held until next rdata_vld.
REQ-015 init_done  output  1  high once init complete, stays high until reset.

Function
REQ-016 FSM states: INIT, RUN; reset enters INIT if INIT_EN=1, else RUN.
REQ-017 INIT: counter 0..depth-1, one write per cycle, D=0, all bits enabled; req_rdy=0.
REQ-018 INIT->RUN on the cycle the address depth-1 is written; init_done rises the next cycle; INIT lasts exactly depth cycles.
REQ-019 RUN: req_rdy=1 every cycle (single port, one access per cycle, no back-pressure).
REQ-020 Accepted write: SRAM CEN=0, GWEN=0, WEN=~req_wmask, D=req_wdata; only masked-in bits change.
REQ-021 Accepted write with req_wmask all-zero: no SRAM access (CEN=1), no state change.
REQ-022 Accepted read: CEN=0, GWEN=1; OUT_REG=0 -> rdata_vld/rdata the next cycle; OUT_REG=1 -> two cycles later.
REQ-023 Back-to-back reads pipeline fully: one rdata_vld per accepted read, in order, no bubbles.
REQ-024 Write followed by read of same address on next cycle returns the new data (no bypass needed; SRAM is write-then-read).
REQ-025 Write in the cycle a pipelined read is in flight (OUT_REG=1) does not corrupt the in-flight rdata.
REQ-026 No accepted request / idle: CEN=1.
REQ-027 rdata holds last value between pulses; no X on rdata after reset.

Reset
REQ-028 On cpurst_b low: FSM->INIT (or RUN if INIT_EN=0), counter=0, req_rdy=0 (1 if INIT_EN=0), init_done=0 (1 if INIT_EN=0), rdata_vld=0, rdata=0, pipeline valids cleared.
REQ-029 Reset mid-INIT restarts fill from address 0; reset mid-read drops the pending rdata_vld.
REQ-030 SRAM array contents are not reset; only INIT zeroes them.

Structure
REQ-031 No shared package; parameters are module parameters, FSM encoding a local constant.
REQ-032 One sub-module ct_f_spsram_param (behavioural SRAM, params ADDR_WIDTH/DATA_WIDTH, ports A, CEN, CLK, D, GWEN, WEN, Q; active-low enables, per-bit WEN, registered Q).
REQ-033 Controller contains FSM, init counter, request mux, read-valid pipeline, optional output register.

Verification
REQ-034 ADDR_WIDTH=4, INIT_EN=1: release reset -> req_rdy=0 for 16 cycles, init_done=1 on cycle 17; read all 16 addrs -> all 0x00000000.
REQ-035 Write addr 3 = 0xDEADBEEF mask 0xFFFFFFFF, then write addr 3 = 0x12345678 mask 0x0000FFFF, read addr 3 -> 0xDEAD5678.
REQ-036 OUT_REG=1: reads addr 0,1,2 back-to-back (data 0x11,0x22,0x33) -> rdata_vld in 3 consecutive cycles starting 2 cycles after first, data in order.
REQ-037 Write addr 5 = 0xA5A5A5A5, read addr 5 next cycle -> 0xA5A5A5A5; write mask 0 to addr 5 = 0xFFFFFFFF -> CEN stays 1, read still 0xA5A5A5A5.
REQ-038 Assert cpurst_b low at INIT count 7 -> restart; init_done high exactly 16 cycles after second release; pending read at reset produces no rdata_vld.
REQ-039 INIT_EN=0: req_rdy=1 and init_done=1 first cycle after reset release.
